// File: rtl/rtc_time_setter_pkg.sv
// ============================================================================
// Module  : rtc_time_setter_pkg
// Brief   : Shared types, field limits and wrap helpers for the RTC time setter
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package rtc_time_setter_pkg;

    localparam int HH_W = 5;
    localparam int MM_W = 6;

    localparam logic [HH_W-1:0] HH_MAX = 5'd23;
    localparam logic [MM_W-1:0] MM_MAX = 6'd59;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SET_HH = 2'd1,
        ST_SET_MM = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    function automatic logic [HH_W-1:0] hh_step(input logic [HH_W-1:0] v, input logic up);
        if (up)
            return (v >= HH_MAX) ? '0 : v + 1'b1;
        else
            return (v == '0) ? HH_MAX : v - 1'b1;
    endfunction

    function automatic logic [MM_W-1:0] mm_step(input logic [MM_W-1:0] v, input logic up);
        if (up)
            return (v >= MM_MAX) ? '0 : v + 1'b1;
        else
            return (v == '0) ? MM_MAX : v - 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rtc_btn_conditioner.sv
// ============================================================================
// Module  : rtc_btn_conditioner
// Brief   : Synchronizer, debounce, press pulse and optional auto-repeat
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rtc_btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 16,
    parameter int REPEAT_CYCLES   = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    input  logic repeat_en,
    output logic press_evt
);

    localparam int c_db_w  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_rep_m = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int c_rep_w = $clog2(c_rep_m + 1);

    localparam logic [c_db_w-1:0]  c_db_last   = c_db_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_rep_w-1:0] c_hold_last = c_rep_w'(HOLD_CYCLES - 1);
    localparam logic [c_rep_w-1:0] c_rep_last  = c_rep_w'(REPEAT_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic               r_level_q;
    logic               r_press;
    logic               r_rep;
    logic               r_repeating;
    logic [c_db_w-1:0]  r_db_cnt;
    logic [c_rep_w-1:0] r_rep_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_level     <= 1'b0;
            r_level_q   <= 1'b0;
            r_press     <= 1'b0;
            r_rep       <= 1'b0;
            r_repeating <= 1'b0;
            r_db_cnt    <= '0;
            r_rep_cnt   <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;

            // Accepted level flips only after a full run of differing samples
            if (r_sync2 != r_level) begin
                if (r_db_cnt == c_db_last) begin
                    r_level  <= r_sync2;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end else begin
                r_db_cnt <= '0;
            end

            r_level_q <= r_level;
            r_press   <= r_level & ~r_level_q;
            r_rep     <= 1'b0;

            // Repeat timer restarts on the press edge, first gap HOLD then REPEAT
            if (!(r_level && repeat_en) || !r_level_q) begin
                r_rep_cnt   <= '0;
                r_repeating <= 1'b0;
            end else if ((!r_repeating && r_rep_cnt == c_hold_last) ||
                         ( r_repeating && r_rep_cnt == c_rep_last)) begin
                r_rep       <= 1'b1;
                r_rep_cnt   <= '0;
                r_repeating <= 1'b1;
            end else begin
                r_rep_cnt <= r_rep_cnt + 1'b1;
            end
        end
    end

    assign press_evt = r_press | r_rep;

endmodule

`default_nettype wire

// File: rtl/rtc_time_setter.sv
// ============================================================================
// Module  : rtc_time_setter
// Brief   : Push-button hour/minute edit session producing an RTC time load
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rtc_time_setter
    import rtc_time_setter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 16,
    parameter int REPEAT_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            btn_mode,
    input  logic            btn_inc,
    input  logic            btn_dec,
    input  logic [HH_W-1:0] cur_hh,
    input  logic [MM_W-1:0] cur_mm,
    output logic [HH_W-1:0] initial_time_hh,
    output logic [MM_W-1:0] initial_time_mm,
    output logic            initial_time_valid,
    output logic            set_active,
    output logic            set_field,
    output logic [HH_W-1:0] disp_hh,
    output logic [MM_W-1:0] disp_mm
);

    localparam int c_to_w = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT_CYCLES - 1);

    logic w_mode_evt;
    logic w_inc_evt;
    logic w_dec_evt;

    rtc_btn_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .HOLD_CYCLES    (HOLD_CYCLES),
        .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_btn_mode (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw  (btn_mode),
        .repeat_en(1'b0),
        .press_evt(w_mode_evt)
    );

    rtc_btn_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .HOLD_CYCLES    (HOLD_CYCLES),
        .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_btn_inc (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw  (btn_inc),
        .repeat_en(1'b1),
        .press_evt(w_inc_evt)
    );

    rtc_btn_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .HOLD_CYCLES    (HOLD_CYCLES),
        .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_btn_dec (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw  (btn_dec),
        .repeat_en(1'b1),
        .press_evt(w_dec_evt)
    );

    state_t            r_state;
    logic [HH_W-1:0]   r_edit_hh;
    logic [MM_W-1:0]   r_edit_mm;
    logic [c_to_w-1:0] r_to_cnt;
    logic [HH_W-1:0]   r_init_hh;
    logic [MM_W-1:0]   r_init_mm;
    logic              r_valid;
    logic              r_set_active;
    logic              r_set_field;
    logic [HH_W-1:0]   r_disp_hh;
    logic [MM_W-1:0]   r_disp_mm;

    state_t          w_state_nxt;
    logic [HH_W-1:0] w_hh_nxt;
    logic [MM_W-1:0] w_mm_nxt;
    logic            w_any_evt;
    logic            w_step;
    logic            w_up;
    logic            w_timeout;
    logic            w_active_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_hh_nxt    = r_edit_hh;
        w_mm_nxt    = r_edit_mm;
        w_any_evt   = w_mode_evt | w_inc_evt | w_dec_evt;
        // Mode wins over inc/dec; inc together with dec cancels out
        w_step      = ~w_mode_evt & (w_inc_evt ^ w_dec_evt);
        w_up        = w_inc_evt;
        w_timeout   = (r_to_cnt == c_to_last) & ~w_any_evt;

        case (r_state)
            ST_IDLE: begin
                if (w_mode_evt) begin
                    w_state_nxt = ST_SET_HH;
                    w_hh_nxt    = (cur_hh > HH_MAX) ? '0 : cur_hh;
                    w_mm_nxt    = (cur_mm > MM_MAX) ? '0 : cur_mm;
                end
            end
            ST_SET_HH: begin
                if (w_mode_evt)
                    w_state_nxt = ST_SET_MM;
                else if (w_timeout)
                    w_state_nxt = ST_IDLE;
                else if (w_step)
                    w_hh_nxt = hh_step(r_edit_hh, w_up);
            end
            ST_SET_MM: begin
                if (w_mode_evt)
                    w_state_nxt = ST_COMMIT;
                else if (w_timeout)
                    w_state_nxt = ST_IDLE;
                else if (w_step)
                    w_mm_nxt = mm_step(r_edit_mm, w_up);
            end
            ST_COMMIT: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase

        w_active_nxt = (w_state_nxt == ST_SET_HH) || (w_state_nxt == ST_SET_MM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_edit_hh    <= '0;
            r_edit_mm    <= '0;
            r_to_cnt     <= '0;
            r_init_hh    <= '0;
            r_init_mm    <= '0;
            r_valid      <= 1'b0;
            r_set_active <= 1'b0;
            r_set_field  <= 1'b0;
            r_disp_hh    <= '0;
            r_disp_mm    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_edit_hh <= w_hh_nxt;
            r_edit_mm <= w_mm_nxt;

            if (w_any_evt || !w_active_nxt)
                r_to_cnt <= '0;
            else
                r_to_cnt <= r_to_cnt + 1'b1;

            r_valid <= (r_state == ST_COMMIT);
            if (r_state == ST_COMMIT) begin
                r_init_hh <= r_edit_hh;
                r_init_mm <= r_edit_mm;
            end

            r_set_active <= w_active_nxt;
            r_set_field  <= (w_state_nxt == ST_SET_MM);
            r_disp_hh    <= w_active_nxt ? w_hh_nxt : cur_hh;
            r_disp_mm    <= w_active_nxt ? w_mm_nxt : cur_mm;
        end
    end

    assign initial_time_hh    = r_init_hh;
    assign initial_time_mm    = r_init_mm;
    assign initial_time_valid = r_valid;
    assign set_active         = r_set_active;
    assign set_field          = r_set_field;
    assign disp_hh            = r_disp_hh;
    assign disp_mm            = r_disp_mm;

endmodule

`default_nettype wire

// File: tb/tb_rtc_time_setter.sv
// ============================================================================
// Module  : tb_rtc_time_setter
// Brief   : Directed self-checking bench for rtc_time_setter
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rtc_time_setter;

    logic       clk;
    logic       rst_n;
    logic       btn_mode;
    logic       btn_inc;
    logic       btn_dec;
    logic [4:0] cur_hh;
    logic [5:0] cur_mm;
    logic [4:0] initial_time_hh;
    logic [5:0] initial_time_mm;
    logic       initial_time_valid;
    logic       set_active;
    logic       set_field;
    logic [4:0] disp_hh;
    logic [5:0] disp_mm;

    int n_checks = 0;
    int n_pass   = 0;
    int n_valid  = 0;

    rtc_time_setter #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (16),
        .REPEAT_CYCLES  (4),
        .TIMEOUT_CYCLES (1024)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .btn_mode          (btn_mode),
        .btn_inc           (btn_inc),
        .btn_dec           (btn_dec),
        .cur_hh            (cur_hh),
        .cur_mm            (cur_mm),
        .initial_time_hh   (initial_time_hh),
        .initial_time_mm   (initial_time_mm),
        .initial_time_valid(initial_time_valid),
        .set_active        (set_active),
        .set_field         (set_field),
        .disp_hh           (disp_hh),
        .disp_mm           (disp_mm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (initial_time_valid) n_valid++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    // mask bit0 = mode, bit1 = inc, bit2 = dec; raw held for n clock samples
    task automatic press(input logic [2:0] mask, input int n);
        @(negedge clk);
        {btn_dec, btn_inc, btn_mode} = mask;
        repeat (n) @(negedge clk);
        {btn_dec, btn_inc, btn_mode} = 3'b000;
        repeat (12) @(negedge clk);
    endtask

    task automatic tap(input logic [2:0] mask);
        press(mask, 6);
    endtask

    initial begin
        rst_n = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        cur_hh = 5'd10; cur_mm = 6'd30;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_hh",     initial_time_hh, 0);
        check("rst_mm",     initial_time_mm, 0);
        check("rst_valid",  initial_time_valid, 0);
        check("rst_active", set_active, 0);
        check("rst_field",  set_field, 0);
        check("rst_disp",   {disp_hh, disp_mm}, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_active", set_active, 0);
        check("idle_disp_hh", disp_hh, 10);

        // Full set from 10:30
        tap(3'b001);
        check("set_active", set_active, 1);
        check("set_field_hh", set_field, 0);
        check("seed_hh", disp_hh, 10);
        check("seed_mm", disp_mm, 30);
        repeat (3) tap(3'b010);
        check("inc3_hh", disp_hh, 13);
        tap(3'b001);
        check("set_field_mm", set_field, 1);
        repeat (31) tap(3'b100);
        check("dec31_mm", disp_mm, 59);
        check("dec31_hh", disp_hh, 13);
        n_valid = 0;
        tap(3'b001);
        check("commit_pulses", n_valid, 1);
        check("commit_hh", initial_time_hh, 13);
        check("commit_mm", initial_time_mm, 59);
        check("commit_active", set_active, 0);
        check("commit_valid_low", initial_time_valid, 0);

        // Wrap boundaries from 23:59
        cur_hh = 5'd23; cur_mm = 6'd59;
        tap(3'b001);
        check("wrap_seed_hh", disp_hh, 23);
        tap(3'b010);
        check("hh_23_inc", disp_hh, 0);
        tap(3'b100);
        check("hh_0_dec", disp_hh, 23);
        tap(3'b001);
        tap(3'b010);
        check("mm_59_inc", disp_mm, 0);
        check("mm_wrap_hh", disp_hh, 23);
        tap(3'b100);
        check("mm_0_dec", disp_mm, 59);
        n_valid = 0;
        tap(3'b001);
        check("wrap_commit_pulses", n_valid, 1);
        check("wrap_commit", {initial_time_hh, initial_time_mm}, {5'd23, 6'd59});

        // Auto-repeat: press + 5 repeats from 08
        cur_hh = 5'd8; cur_mm = 6'd0;
        tap(3'b001);
        press(3'b010, 35);
        check("repeat_hh", disp_hh, 14);

        // Debounce boundaries
        press(3'b010, 2);
        check("db_2", disp_hh, 14);
        press(3'b010, 3);
        check("db_3", disp_hh, 14);
        press(3'b010, 4);
        check("db_4", disp_hh, 15);

        // Exact latency: change lands on edge N+7
        @(negedge clk);
        btn_inc = 1'b1;
        repeat (7) @(posedge clk);
        #1 check("lat_n6", disp_hh, 15);
        @(posedge clk);
        #1 check("lat_n7", disp_hh, 16);
        repeat (2) @(posedge clk);
        @(negedge clk);
        btn_inc = 1'b0;
        repeat (20) @(negedge clk);
        check("lat_total", disp_hh, 16);

        // Simultaneous events
        tap(3'b110);
        check("incdec_hh", disp_hh, 16);
        tap(3'b011);
        check("modeinc_field", set_field, 1);
        check("modeinc_hh", disp_hh, 16);
        check("modeinc_mm", disp_mm, 0);

        // Timeout abort in SET_MM
        n_valid = 0;
        repeat (1000) @(negedge clk);
        check("to_before", set_active, 1);
        repeat (20) @(negedge clk);
        check("to_after", set_active, 0);
        check("to_no_valid", n_valid, 0);
        check("to_keep", {initial_time_hh, initial_time_mm}, {5'd23, 6'd59});

        // Out-of-range seed clamp, then reset mid-edit
        cur_hh = 5'd27; cur_mm = 6'd61;
        tap(3'b001);
        check("clamp_hh", disp_hh, 0);
        check("clamp_mm", disp_mm, 0);
        tap(3'b010);
        check("clamp_inc", disp_hh, 1);
        n_valid = 0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_active", set_active, 0);
        check("midrst_init", {initial_time_hh, initial_time_mm}, 0);
        check("midrst_disp", {disp_hh, disp_mm}, 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("midrst_idle", set_active, 0);
        check("midrst_no_valid", n_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
